branch_sequencer: RTL and testbench
===================================

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 SHALL declare ports in this order: clock first, then clear.
- clock  in  1  system clock; all state changes on its rising edge.
- clear  in  1  asynchronous, active-low reset.
REQ-002 SHALL declare the remaining inputs as:
- start  in  1  one-cycle pulse; IR holds a decoded conditional-branch instruction.
- IR  in  32  instruction register.
- con  in  1  branch-condition result from the condition flip-flop; valid from the cycle after con_en rises.
REQ-003 SHALL declare the outputs, all registered, as:
- gra  out  1  select Ra field for the register file.
- r_out  out  1  register file drives the bus.
- con_en  out  1  rising edge makes the condition flip-flop evaluate IR[20:19] against the bus.
- pc_out  out  1  PC drives the bus.
- y_in  out  1  load Y.
- c_out  out  1  sign-extended IR[18:0] drives the bus.
- alu_add  out  1  ALU performs ADD.
- z_in  out  1  load Z.
- zlo_out  out  1  Z[31:0] drives the bus.
- pc_in  out  1  load PC.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- taken  out  1  branch outcome of the last completed sequence.

Function
REQ-004 SHALL implement a one-hot FSM with states IDLE, T3, T4, T5, T6 and FIN.
REQ-005 SHALL move from IDLE to T3 on the first edge where start=1; start=0 SHALL hold IDLE.
REQ-006 SHALL advance T3->T4->T5->T6->FIN->IDLE unconditionally, one state per clock.
REQ-007 SHALL make the latency from start to done exactly 5 clocks, with done high only in FIN.
REQ-008 SHALL assert, for exactly one cycle each, only these strobes per state:
- T3: gra, r_out, con_en.
- T4: pc_out, y_in.
- T5: c_out, alu_add, z_in.
- T6: zlo_out, and pc_in only if the latched condition = 1.
REQ-009 SHALL deassert con_en in every state except T3, so each sequence gives exactly one rising edge.
REQ-010 SHALL sample con into an internal register cond_q at the end of T4, and SHALL NOT consult con in any other state.
REQ-011 SHALL update taken from cond_q on entry to FIN and hold it until the next FIN or reset.
REQ-012 SHALL assert busy in T3 through FIN inclusive and keep it low in IDLE.
REQ-013 SHALL ignore start while busy=1: no queueing, no restart, no error.
REQ-014 SHALL accept start in the IDLE cycle directly after FIN, allowing back-to-back branches 6 clocks apart.
REQ-015 SHALL NOT sample or modify IR; IR stability from T3 to T6 is the upstream controller's duty.
REQ-016 SHALL never assert two bus-drive strobes (r_out, pc_out, c_out, zlo_out) in the same cycle.
REQ-017 SHALL send any illegal one-hot state encoding to IDLE on the next clock, with all strobes low.

Reset
REQ-018 SHALL, while clear=0, force IDLE and all outputs to 0 (including taken) and cond_q to 0, regardless of clock.
REQ-019 SHALL, on reset asserted mid-sequence, drop all strobes immediately and leave pc_in unasserted.
REQ-020 SHALL, after clear is released, take no action until a new start is seen.

Structure
REQ-021 SHALL place the state encodings and a shared ADD opcode constant in the shared control package (ctrl_pkg).
REQ-022 SHALL be a single module with no sub-modules; the condition flip-flop stays outside and connects via con_en/con.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- BRZR, IR[20:19]=00, bus=0, con=1 after T3: pc_in high in T6, taken=1, done pulse 5 clocks after start.
- BRNZ, IR[20:19]=01, bus=0, con=0: pc_in never asserted, zlo_out still pulses in T6, taken=0.
- start pulsed again in T4: ignored; exactly one done pulse; con_en has a single rising edge.
- Back-to-back start in the IDLE cycle after FIN, taken then not-taken: two done pulses 6 clocks apart; taken = 1 then 0.
- clear driven low during T5: all outputs 0 asynchronously, no pc_in; after release, FSM stays IDLE with start=0.
- Every cycle of every run: at most one of r_out, pc_out, c_out, zlo_out is high.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared control-unit state encodings, strobe bundle and ALU opcode
package ctrl_pkg;

   // One-hot sequencer states; any other encoding is treated as illegal.
   typedef enum logic [5:0] {
      IDLE = 6'b000001,
      T3   = 6'b000010,
      T4   = 6'b000100,
      T5   = 6'b001000,
      T6   = 6'b010000,
      FIN  = 6'b100000
   } state_t;

   // ALU opcode for ADD, shared by every controller that drives the ALU.
   localparam logic [4:0] ALU_OP_ADD = 5'b00011;

   // Control strobes produced by the branch sequencer for one cycle.
   typedef struct packed {
      logic gra;
      logic r_out;
      logic con_en;
      logic pc_out;
      logic y_in;
      logic c_out;
      logic alu_add;
      logic z_in;
      logic zlo_out;
      logic pc_in;
      logic busy;
      logic done;
   } strobes_t;

   // Strobes that belong to a given state; pc_in in T6 follows the latched condition.
   function automatic strobes_t decode_strobes(input state_t st, input logic cond);
      strobes_t s;
      s = '0;
      case (st)
         T3: begin
            s.gra    = 1'b1;
            s.r_out  = 1'b1;
            s.con_en = 1'b1;
            s.busy   = 1'b1;
         end
         T4: begin
            s.pc_out = 1'b1;
            s.y_in   = 1'b1;
            s.busy   = 1'b1;
         end
         T5: begin
            s.c_out   = 1'b1;
            s.alu_add = 1'b1;
            s.z_in    = 1'b1;
            s.busy    = 1'b1;
         end
         T6: begin
            s.zlo_out = 1'b1;
            s.pc_in   = cond;
            s.busy    = 1'b1;
         end
         FIN: begin
            s.busy = 1'b1;
            s.done = 1'b1;
         end
         default: s = '0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - T3..T6 control sequence for conditional branch instructions
module branch_sequencer
   import ctrl_pkg::*;
(
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic [31:0] IR,
   input  logic        con,
   output logic        gra,
   output logic        r_out,
   output logic        con_en,
   output logic        pc_out,
   output logic        y_in,
   output logic        c_out,
   output logic        alu_add,
   output logic        z_in,
   output logic        zlo_out,
   output logic        pc_in,
   output logic        busy,
   output logic        done,
   output logic        taken
);

   state_t   state_q, state_d;
   strobes_t out_q, out_d;
   logic     cond_q;
   logic     taken_q;

   // IR is decoded by the datapath (condition field, immediate); the sequencer never looks at it.
   logic unused_ir;
   assign unused_ir = ^IR;

   // Next-state decode and the strobes for the state being entered, so outputs come straight from flops.
   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE:    state_d = start ? T3 : IDLE;
         T3:      state_d = T4;
         T4:      state_d = T5;
         T5:      state_d = T6;
         T6:      state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      out_d = decode_strobes(state_d, cond_q);
   end

   // State and output registers; clear wipes every strobe immediately so a half-done branch never loads PC.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= IDLE;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
      end
   end

   // Condition is only trusted at the end of T4, one cycle after the con_en rising edge in T3.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         cond_q <= 1'b0;
      end else if (state_q == T4) begin
         cond_q <= con;
      end
   end

   // Branch outcome is published on entry to FIN and held until the next completion.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         taken_q <= 1'b0;
      end else if (state_d == FIN) begin
         taken_q <= cond_q;
      end
   end

   assign gra     = out_q.gra;
   assign r_out   = out_q.r_out;
   assign con_en  = out_q.con_en;
   assign pc_out  = out_q.pc_out;
   assign y_in    = out_q.y_in;
   assign c_out   = out_q.c_out;
   assign alu_add = out_q.alu_add;
   assign z_in    = out_q.z_in;
   assign zlo_out = out_q.zlo_out;
   assign pc_in   = out_q.pc_in;
   assign busy    = out_q.busy;
   assign done    = out_q.done;
   assign taken   = taken_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - scoreboard bench for branch_sequencer directed scenarios
module tb_branch_sequencer;

   logic        clock;
   logic        clear;
   logic        start;
   logic [31:0] IR;
   logic        con;
   logic        gra, r_out, con_en, pc_out, y_in, c_out, alu_add, z_in, zlo_out, pc_in;
   logic        busy, done, taken;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   typedef struct {
      int   done_cyc;
      logic taken;
   } exp_t;
   exp_t exp_q[$];

   logic cond_target = 1'b0;

   branch_sequencer dut (
      .clock   (clock),
      .clear   (clear),
      .start   (start),
      .IR      (IR),
      .con     (con),
      .gra     (gra),
      .r_out   (r_out),
      .con_en  (con_en),
      .pc_out  (pc_out),
      .y_in    (y_in),
      .c_out   (c_out),
      .alu_add (alu_add),
      .z_in    (z_in),
      .zlo_out (zlo_out),
      .pc_in   (pc_in),
      .busy    (busy),
      .done    (done),
      .taken   (taken)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Condition flip-flop model: evaluates on the con_en rising edge.
   always @(posedge con_en) con = cond_target;

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: per-cycle bus exclusivity and scoreboard pop on every done pulse.
   int   rises = 0;
   int   pcin_n = 0;
   int   zlo_n = 0;
   int   zlo_cyc = -1;
   logic prev_con_en = 1'b0;
   always @(negedge clock) begin
      exp_t e;
      if (!clear) begin
         rises  = 0;
         pcin_n = 0;
         zlo_n  = 0;
      end else begin
         check("bus_exclusive", int'($countones({r_out, pc_out, c_out, zlo_out}) <= 1), 1);
         if (con_en && !prev_con_en) rises++;
         if (pc_in) pcin_n++;
         if (zlo_out) begin
            zlo_n++;
            zlo_cyc = cyc;
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL sb_unexpected_done: done at cycle %0d, none expected", cyc);
            end else begin
               e = exp_q.pop_front();
               check("done_cycle", cyc, e.done_cyc);
               check("taken", int'(taken), int'(e.taken));
               check("busy_in_fin", int'(busy), 1);
               check("con_en_rises", rises, 1);
               check("pc_in_pulses", pcin_n, int'(e.taken));
               check("zlo_out_pulses", zlo_n, 1);
               check("zlo_in_t6", zlo_cyc, cyc - 1);
            end
            rises  = 0;
            pcin_n = 0;
            zlo_n  = 0;
         end
      end
      prev_con_en = con_en;
   end

   // Issue one branch starting in the current (IDLE) cycle; returns in the FIN cycle.
   task automatic run_branch(input logic [1:0] cc, input logic c, input logic restart);
      IR          = 32'h0000_0010 | (32'(cc) << 19);
      cond_target = c;
      start       = 1'b1;
      exp_q.push_back('{cyc + 5, c});
      for (int k = 1; k <= 5; k++) begin
         @(negedge clock);
         start = (restart && k == 2);
         if (k == 3) con = ~c;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      clear = 1'b1;
      start = 1'b0;
      IR    = 32'h0;
      con   = 1'b0;
      #1 clear = 1'b0;
      #1;
      check("reset_outputs",
            int'({gra, r_out, con_en, pc_out, y_in, c_out, alu_add, z_in, zlo_out, pc_in, busy, done, taken}), 0);
      repeat (2) @(negedge clock);
      clear = 1'b1;
      repeat (2) @(negedge clock);
      check("idle_after_release", int'(busy), 0);

      // BRZR taken
      run_branch(2'b00, 1'b1, 1'b0);
      repeat (3) @(negedge clock);
      // BRNZ not taken
      run_branch(2'b01, 1'b0, 1'b0);
      repeat (3) @(negedge clock);
      // back-to-back: taken then not taken
      run_branch(2'b00, 1'b1, 1'b0);
      @(negedge clock);
      run_branch(2'b01, 1'b0, 1'b0);
      repeat (3) @(negedge clock);
      // start pulsed again in T4 must be ignored
      run_branch(2'b00, 1'b1, 1'b1);
      repeat (8) @(negedge clock);
      check("taken_held", int'(taken), 1);

      // clear asserted during T5
      cond_target = 1'b1;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check("t5_c_out", int'(c_out), 1);
      #2 clear = 1'b0;
      #1;
      check("async_clear_outputs",
            int'({gra, r_out, con_en, pc_out, y_in, c_out, alu_add, z_in, zlo_out, pc_in, busy, done, taken}), 0);
      repeat (2) begin
         @(negedge clock);
         check("pc_in_in_reset", int'(pc_in), 0);
      end
      clear = 1'b1;
      repeat (6) begin
         @(negedge clock);
         check("stay_idle_busy", int'(busy), 0);
         check("stay_idle_pc_in", int'(pc_in), 0);
      end

      check("sb_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
